// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one TX_uart between NUM_REQ byte requesters.
// It latches the winner's byte and baud, pulses start and holds the configuration until the frame is done.
module uart_tx_arbiter #(
   parameter int         NUM_REQ       = 4,
   parameter logic [2:0] DEFAULT_BAUD  = 3'd4,
   parameter int         START_TIMEOUT = 64
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [8*NUM_REQ-1:0] req_data,
   input  logic [3*NUM_REQ-1:0] req_baud,
   output logic [NUM_REQ-1:0]   req_ready,
   output logic                 tx_start,
   output logic [7:0]           tx_data,
   output logic [2:0]           tx_baud_sel,
   input  logic                 tx_ready,
   input  logic                 tx_busy,
   output logic [2:0]           owner,
   output logic                 active,
   output logic                 timeout_err
);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_GRANT     = 3'd1,
      S_START     = 3'd2,
      S_WAIT_BUSY = 3'd3,
      S_WAIT_DONE = 3'd4,
      S_DONE      = 3'd5
   } state_t;

   localparam logic [7:0] TIMEOUT_LAST   = 8'(START_TIMEOUT - 2);
   localparam logic [2:0] LAST_GRANT_RST = 3'(NUM_REQ - 1);

   state_t     state_r;
   logic [2:0] last_grant_r;
   logic [7:0] cnt_r;
   logic [2:0] pick_s;
   logic       pick_vld_s;

   function automatic logic [NUM_REQ-1:0] onehot(input logic [2:0] idx);
      return {{(NUM_REQ-1){1'b0}}, 1'b1} << idx;
   endfunction

   // Round-robin scan: first valid requester starting just after the last one served
   always_comb begin
      int                 idx;
      logic [NUM_REQ-1:0] rv;
      pick_s     = 3'd0;
      pick_vld_s = 1'b0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = int'(last_grant_r) + k;
         idx = (idx >= NUM_REQ) ? idx - NUM_REQ : idx;
         rv  = req_valid >> idx;
         if (!pick_vld_s && rv[0]) begin
            pick_s     = 3'(idx);
            pick_vld_s = 1'b1;
         end else begin
            pick_s     = pick_s;
            pick_vld_s = pick_vld_s;
         end
      end
   end

   // Sequencing FSM with all outputs registered
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r      <= S_IDLE;
         last_grant_r <= LAST_GRANT_RST;
         cnt_r        <= 8'd0;
         req_ready    <= '0;
         tx_start     <= 1'b0;
         tx_data      <= 8'd0;
         tx_baud_sel  <= DEFAULT_BAUD;
         owner        <= 3'd0;
         active       <= 1'b0;
         timeout_err  <= 1'b0;
      end else begin
         req_ready <= '0;
         tx_start  <= 1'b0;
         case (state_r)
            S_IDLE: begin
               if (tx_ready && pick_vld_s) begin
                  owner     <= pick_s;
                  req_ready <= onehot(pick_s);
                  active    <= 1'b1;
                  state_r   <= S_GRANT;
               end else begin
                  state_r   <= S_IDLE;
               end
            end
            S_GRANT: begin
               tx_data     <= 8'(req_data >> {owner, 3'b000});
               tx_baud_sel <= 3'(req_baud >> (6'(owner) * 6'd3));
               tx_start    <= 1'b1;
               state_r     <= S_START;
            end
            S_START: begin
               cnt_r   <= 8'd0;
               state_r <= S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
               if (tx_busy) begin
                  state_r <= S_WAIT_DONE;
               end else if (cnt_r == TIMEOUT_LAST) begin
                  // Transmitter never answered: drop the byte and move the pointer on
                  cnt_r        <= cnt_r + 8'd1;
                  timeout_err  <= 1'b1;
                  last_grant_r <= owner;
                  active       <= 1'b0;
                  state_r      <= S_IDLE;
               end else begin
                  cnt_r <= (cnt_r == 8'hFF) ? cnt_r : cnt_r + 8'd1;
               end
            end
            S_WAIT_DONE: begin
               if (!tx_busy && tx_ready) begin
                  state_r <= S_DONE;
               end else begin
                  state_r <= S_WAIT_DONE;
               end
            end
            S_DONE: begin
               last_grant_r <= owner;
               active       <= 1'b0;
               state_r      <= S_IDLE;
            end
            default: begin
               active  <= 1'b0;
               state_r <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a small behavioural TX_uart stub in place of the transmitter.
// The stub records each started frame as the byte the loopback receiver would see.
module tb_uart_tx_arbiter;

   localparam int NUM_REQ       = 4;
   localparam int START_TIMEOUT = 16;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic [NUM_REQ-1:0]   req_valid;
   logic [8*NUM_REQ-1:0] req_data;
   logic [3*NUM_REQ-1:0] req_baud;
   logic [NUM_REQ-1:0]   req_ready;
   logic                 tx_start;
   logic [7:0]           tx_data;
   logic [2:0]           tx_baud_sel;
   logic                 tx_ready;
   logic                 tx_busy;
   logic [2:0]           owner;
   logic                 active;
   logic                 timeout_err;

   uart_tx_arbiter #(
      .NUM_REQ       (NUM_REQ),
      .DEFAULT_BAUD  (3'd4),
      .START_TIMEOUT (START_TIMEOUT)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_data    (req_data),
      .req_baud    (req_baud),
      .req_ready   (req_ready),
      .tx_start    (tx_start),
      .tx_data     (tx_data),
      .tx_baud_sel (tx_baud_sel),
      .tx_ready    (tx_ready),
      .tx_busy     (tx_busy),
      .owner       (owner),
      .active      (active),
      .timeout_err (timeout_err)
   );

   // 50 MHz clock
   always #10 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   // stub and scoreboard state
   logic       stub_on;
   int         busy_left;
   logic [7:0] cap_data;
   logic [2:0] cap_baud;
   int         grant_q[$];
   logic [7:0] rx_data_q[$];
   logic [2:0] rx_baud_q[$];
   int         exp_gr[$];
   logic [7:0] exp_rx[$];
   logic [2:0] exp_bd[$];
   int         tick_n;
   int         fall_tick;
   logic       gap_check;
   int         reload_left[NUM_REQ];
   int         round_n[NUM_REQ];
   logic [NUM_REQ-1:0] reload_pend;
   logic [7:0] prev_data;
   logic [2:0] prev_baud;
   logic       prev_grant_seen;

   task automatic request(input int i, input logic [7:0] d, input logic [2:0] b);
      req_data[8*i +: 8] = d;
      req_baud[3*i +: 3] = b;
      req_valid[i]       = 1'b1;
   endtask

   // one clock: sample just after the edge, play requesters and TX stub
   task automatic tick();
      @(posedge clk);
      #1;
      tick_n++;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (reload_pend[i]) begin
            request(i, 8'(16 * i + round_n[i]), 3'(i));
            reload_pend[i] = 1'b0;
         end
      end
      if (!rst_n) begin
         tx_busy   = 1'b0;
         tx_ready  = 1'b1;
         busy_left = 0;
      end else begin
         if ((tx_data !== prev_data) || (tx_baud_sel !== prev_baud))
            check("cfg_change_in_grant", 32'(prev_grant_seen), 32'd1);
         if (req_ready !== '0) begin
            check("ready_onehot", $countones(req_ready), 32'd1);
            for (int i = 0; i < NUM_REQ; i++) begin
               if (req_ready[i]) begin
                  grant_q.push_back(i);
                  req_valid[i] = 1'b0;
                  if (gap_check && fall_tick >= 0) check("grant_gap", tick_n - fall_tick, 32'd3);
                  if (reload_left[i] > 0) begin
                     reload_left[i]--;
                     round_n[i]++;
                     reload_pend[i] = 1'b1;
                  end
               end
            end
         end
         if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0) begin
               tx_busy   = 1'b0;
               tx_ready  = 1'b1;
               fall_tick = tick_n;
               check("frame_cfg_stable", {21'd0, tx_data, tx_baud_sel}, {21'd0, cap_data, cap_baud});
               rx_data_q.push_back(cap_data);
               rx_baud_q.push_back(cap_baud);
            end
         end
         if (tx_start === 1'b1) begin
            cap_data = tx_data;
            cap_baud = tx_baud_sel;
            if (stub_on) begin
               tx_busy   = 1'b1;
               tx_ready  = 1'b0;
               busy_left = 8;
            end
         end
      end
      prev_data       = tx_data;
      prev_baud       = tx_baud_sel;
      prev_grant_seen = (req_ready != '0);
   endtask

   task automatic run_until_idle(input string tag, input int budget);
      int   n    = 0;
      logic done = 1'b0;
      while (!done && n < budget) begin
         tick();
         n++;
         done = (active == 1'b0) && (req_valid == '0) && (busy_left == 0) && (reload_pend == '0);
      end
      if (!done) check({tag, "_wait_budget"}, 32'd0, 32'd1);
   endtask

   task automatic verify(input string tag);
      check({tag, "_n_grants"}, grant_q.size(), exp_gr.size());
      for (int k = 0; k < exp_gr.size() && k < grant_q.size(); k++)
         check({tag, "_grant"}, grant_q[k], exp_gr[k]);
      check({tag, "_n_rx"}, rx_data_q.size(), exp_rx.size());
      for (int k = 0; k < exp_rx.size() && k < rx_data_q.size(); k++) begin
         check({tag, "_rx_data"}, rx_data_q[k], exp_rx[k]);
         check({tag, "_rx_baud"}, rx_baud_q[k], exp_bd[k]);
      end
      grant_q.delete(); rx_data_q.delete(); rx_baud_q.delete();
      exp_gr.delete();  exp_rx.delete();    exp_bd.delete();
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_req_ready"},   req_ready,   32'd0);
      check({tag, "_tx_start"},    tx_start,    32'd0);
      check({tag, "_tx_data"},     tx_data,     32'd0);
      check({tag, "_tx_baud_sel"}, tx_baud_sel, 32'd4);
      check({tag, "_owner"},       owner,       32'd0);
      check({tag, "_active"},      active,      32'd0);
      check({tag, "_timeout_err"}, timeout_err, 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; req_valid = '0; req_data = '0; req_baud = '0;
      tx_ready = 1'b1; tx_busy = 1'b0; stub_on = 1'b1; busy_left = 0;
      tick_n = 0; fall_tick = -1; gap_check = 1'b0; reload_pend = '0;
      prev_data = 8'd0; prev_baud = 3'd4; prev_grant_seen = 1'b0;
      cap_data = 8'd0; cap_baud = 3'd0;
      for (int i = 0; i < NUM_REQ; i++) begin reload_left[i] = 0; round_n[i] = 0; end
      repeat (3) tick();
      check_reset("rst");
      rst_n = 1'b1;
      tick();

      // single requester, latency and data
      request(0, 8'hAA, 3'd4);
      tick();
      check("t1_req_ready", req_ready, 32'h1);
      check("t1_owner", owner, 32'd0);
      check("t1_active", active, 32'd1);
      tick();
      check("t1_tx_start", tx_start, 32'd1);
      check("t1_tx_data", tx_data, 32'hAA);
      check("t1_tx_baud", tx_baud_sel, 32'd4);
      run_until_idle("t1", 100);
      check("t1_active_end", active, 32'd0);
      exp_gr = '{0}; exp_rx = '{8'hAA}; exp_bd = '{3'd4};
      verify("t1");

      // two requesters raised together
      request(1, 8'h55, 3'd4);
      request(2, 8'h0F, 3'd4);
      run_until_idle("t2", 200);
      exp_gr = '{1, 2}; exp_rx = '{8'h55, 8'h0F}; exp_bd = '{3'd4, 3'd4};
      verify("t2");

      // all four held valid for eight bytes, from reset priority
      rst_n = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
      fall_tick = -1;
      gap_check = 1'b1;
      for (int i = 0; i < NUM_REQ; i++) begin
         reload_left[i] = 1;
         round_n[i]     = 0;
         request(i, 8'(16 * i), 3'(i));
      end
      run_until_idle("t3", 600);
      gap_check = 1'b0;
      exp_gr = '{0, 1, 2, 3, 0, 1, 2, 3};
      exp_rx = '{8'h00, 8'h10, 8'h20, 8'h30, 8'h01, 8'h11, 8'h21, 8'h31};
      exp_bd = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0, 3'd1, 3'd2, 3'd3};
      verify("t3");

      // different bauds back to back
      request(0, 8'hFF, 3'd0);
      run_until_idle("t4a", 100);
      request(1, 8'hF0, 3'd2);
      run_until_idle("t4b", 100);
      exp_gr = '{0, 1}; exp_rx = '{8'hFF, 8'hF0}; exp_bd = '{3'd0, 3'd2};
      verify("t4");

      // transmitter never goes busy: start timeout
      stub_on = 1'b0;
      request(2, 8'h77, 3'd5);
      tick();
      check("t5_req_ready", req_ready, 32'h4);
      tick();
      check("t5_tx_start", tx_start, 32'd1);
      repeat (START_TIMEOUT - 1) tick();
      check("t5_err_early", timeout_err, 32'd0);
      tick();
      check("t5_err_set", timeout_err, 32'd1);
      check("t5_active", active, 32'd0);
      stub_on = 1'b1;
      request(3, 8'h99, 3'd1);
      tick();
      check("t5_next_grant", req_ready, 32'h8);
      run_until_idle("t5", 100);
      check("t5_err_sticky", timeout_err, 32'd1);
      exp_gr = '{2, 3}; exp_rx = '{8'h99}; exp_bd = '{3'd1};
      verify("t5");

      // reset in the middle of a frame
      request(1, 8'hC3, 3'd3);
      for (int n = 0; n < 20 && tx_busy !== 1'b1; n++) tick();
      check("t6_busy_seen", tx_busy, 32'd1);
      repeat (2) tick();
      rst_n = 1'b0;
      repeat (5) tick();
      check_reset("t6_rst");
      rst_n = 1'b1;
      repeat (3) tick();
      exp_gr = '{1};
      verify("t6_abort");
      request(0, 8'h3C, 3'd4);
      run_until_idle("t6", 100);
      exp_gr = '{0}; exp_rx = '{8'h3C}; exp_bd = '{3'd4};
      verify("t6");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
